// File: rtl/rr_arb8x4_if.sv
// Request/data/handshake bundle between eight requesters, the arbiter and the OR-reduction bus.
interface rr_arb8x4_if;
  logic [7:0] REQ;
  logic [3:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [7:0] ACK;
  logic       VALID;
  logic       READY;
  logic [7:0] GNT;
  logic [3:0] O0, O1, O2, O3, O4, O5, O6, O7;

  modport master (
    output REQ, D0, D1, D2, D3, D4, D5, D6, D7, READY,
    input  ACK, VALID, GNT, O0, O1, O2, O3, O4, O5, O6, O7
  );

  modport slave (
    input  REQ, D0, D1, D2, D3, D4, D5, D6, D7, READY,
    output ACK, VALID, GNT, O0, O1, O2, O3, O4, O5, O6, O7
  );
endinterface

// File: rtl/rr_arb8x4.sv
// Round-robin arbiter for eight 4-bit requesters; registers the winner's nibble on its own lane
// and zeroes the rest so the downstream OR-reduction yields exactly the granted nibble.
module rr_arb8x4 (
  input logic        CLK,
  input logic        ASYNCRESETN,
  rr_arb8x4_if.slave bus
);
  localparam int N      = 8;
  localparam int DATA_W = 4;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_p1;
  logic [N-1:0]      gnt_p1;
  logic [DATA_W-1:0] lane_p1 [N];
  logic [2:0]        ptr_p1;

  logic              le;
  logic              any_req;
  logic [2:0]        win;
  logic [N-1:0]      win_oh;
  logic [DATA_W-1:0] d_arr [N];

  // First requester at or after the pointer, scanning with modulo-8 wrap.
  function automatic logic [2:0] pick(input logic [N-1:0] req, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = p + 3'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign d_arr[0] = bus.D0;
  assign d_arr[1] = bus.D1;
  assign d_arr[2] = bus.D2;
  assign d_arr[3] = bus.D3;
  assign d_arr[4] = bus.D4;
  assign d_arr[5] = bus.D5;
  assign d_arr[6] = bus.D6;
  assign d_arr[7] = bus.D7;

  assign le      = (state_p1 == ST_EMPTY) | bus.READY;
  assign any_req = |bus.REQ;
  assign win     = pick(bus.REQ, ptr_p1);
  assign win_oh  = 8'b1 << win;

  // Reset gates ACK so no requester believes it was accepted while the block is held clear.
  assign bus.ACK = (ASYNCRESETN && le && any_req) ? win_oh : 8'h00;

  // Stage p1: registered transfer presented to the OR bus
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_p1 <= ST_EMPTY;
      gnt_p1   <= '0;
      ptr_p1   <= '0;
      for (int k = 0; k < N; k++) lane_p1[k] <= '0;
    end else if (le) begin
      if (any_req) begin
        state_p1 <= ST_FULL;
        gnt_p1   <= win_oh;
        ptr_p1   <= win + 3'd1;
        for (int k = 0; k < N; k++) lane_p1[k] <= win_oh[k] ? d_arr[k] : '0;
      end else begin
        state_p1 <= ST_EMPTY;
        gnt_p1   <= '0;
        for (int k = 0; k < N; k++) lane_p1[k] <= '0;
      end
    end
  end

  assign bus.VALID = (state_p1 == ST_FULL);
  assign bus.GNT   = gnt_p1;
  assign bus.O0    = lane_p1[0];
  assign bus.O1    = lane_p1[1];
  assign bus.O2    = lane_p1[2];
  assign bus.O3    = lane_p1[3];
  assign bus.O4    = lane_p1[4];
  assign bus.O5    = lane_p1[5];
  assign bus.O6    = lane_p1[6];
  assign bus.O7    = lane_p1[7];
endmodule
